// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl: pulls words out of a show-ahead FIFO into a single-entry
// output register and frames them into bursts of BURST beats. A word can be
// handed off and replaced in the same cycle, so one beat per cycle can be
// sustained. It keeps a running count of transferred beats and a sticky
// underflow flag.
module fifo_drain_ctrl #(
   parameter int WIDTH = 8,
   parameter int BURST = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             fifo_ept,
   input  logic             fifo_valid,
   input  logic [WIDTH-1:0] fifo_rdata,
   output logic             fifo_pop,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic [15:0]      xfer_cnt,
   output logic             underflow
);

   // Beat index of the final beat in a burst (BURST is at most 256).
   localparam logic [7:0] LAST_BEAT = 8'(BURST - 1);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_HOLD  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_q,  data_d;
   logic [7:0]       beat_q,  beat_d;
   logic             last_q,  last_d;
   logic [15:0]      cnt_q,   cnt_d;
   logic             unf_q,   unf_d;

   logic             pop_s;
   logic             load_s;
   logic             xfer_s;

   // Handshake decode: pop request, accepted FIFO word and output transfer.
   always_comb begin
      pop_s  = 1'b0;
      load_s = 1'b0;
      xfer_s = 1'b0;
      // Reset gates the pop so the FIFO is never touched while held in reset.
      if (reset && enable && !fifo_ept) begin
         if (state_q == ST_EMPTY) begin
            pop_s = 1'b1;
         end else if (out_ready) begin
            pop_s = 1'b1;
         end else begin
            pop_s = 1'b0;
         end
      end else begin
         pop_s = 1'b0;
      end
      load_s = pop_s && fifo_valid;
      xfer_s = (state_q == ST_HOLD) && out_ready;
   end

   // Next-state, data, burst framing and counters.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      beat_d  = beat_q;
      cnt_d   = cnt_q;
      unf_d   = unf_q;
      last_d  = 1'b0;

      case (state_q)
         ST_EMPTY: begin
            if (load_s) begin
               state_d = ST_HOLD;
            end else begin
               state_d = ST_EMPTY;
            end
         end
         ST_HOLD: begin
            if (xfer_s && !load_s) begin
               state_d = ST_EMPTY;
            end else begin
               state_d = ST_HOLD;
            end
         end
         default: begin
            state_d = ST_EMPTY;
         end
      endcase

      // Only an accepted pop ever replaces the held word.
      if (load_s) begin
         data_d = fifo_rdata;
      end else begin
         data_d = data_q;
      end

      if (xfer_s) begin
         cnt_d = cnt_q + 16'd1;
         if (beat_q == LAST_BEAT) begin
            beat_d = 8'd0;
         end else begin
            beat_d = beat_q + 8'd1;
         end
      end else begin
         cnt_d  = cnt_q;
         beat_d = beat_q;
      end

      // A pop the FIFO could not honour is latched until reset.
      if (pop_s && !fifo_valid) begin
         unf_d = 1'b1;
      end else begin
         unf_d = unf_q;
      end

      // Registered copy of "valid and on the final beat" for the next cycle.
      last_d = (state_d == ST_HOLD) && (beat_d == LAST_BEAT);
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_EMPTY;
         data_q  <= {WIDTH{1'b0}};
         beat_q  <= 8'd0;
         last_q  <= 1'b0;
         cnt_q   <= 16'd0;
         unf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         beat_q  <= beat_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         unf_q   <= unf_d;
      end
   end

   assign fifo_pop  = pop_s;
   assign out_data  = data_q;
   assign out_valid = (state_q == ST_HOLD);
   assign out_last  = last_q;
   assign xfer_cnt  = cnt_q;
   assign underflow = unf_q;

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed bench for fifo_drain_ctrl (WIDTH=8, BURST=4) driven from a small
// show-ahead FIFO model; expected values are written out by hand per step.
module tb_fifo_drain_ctrl;

   logic        clk;
   logic        reset;
   logic        enable;
   logic        fifo_ept;
   logic        fifo_valid;
   logic [7:0]  fifo_rdata;
   logic        fifo_pop;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic [15:0] xfer_cnt;
   logic        underflow;

   int total = 0;
   int bad   = 0;

   // FIFO model: written by the stimulus, read pointer advanced on accepted pops.
   logic [7:0] mem [16];
   int         wr_ptr = 0;
   int         rd_ptr = 0;
   logic       fake_nonempty = 1'b0;
   logic       kill_valid    = 1'b0;

   assign fifo_ept   = (wr_ptr == rd_ptr) && !fake_nonempty;
   assign fifo_valid = fifo_pop && (wr_ptr != rd_ptr) && !kill_valid;
   assign fifo_rdata = mem[rd_ptr % 16];

   // FIFO read side.
   always @(posedge clk) begin
      if (fifo_pop && fifo_valid) rd_ptr <= rd_ptr + 1;
   end

   fifo_drain_ctrl #(.WIDTH(8), .BURST(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .fifo_ept   (fifo_ept),
      .fifo_valid (fifo_valid),
      .fifo_rdata (fifo_rdata),
      .fifo_pop   (fifo_pop),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .xfer_cnt   (xfer_cnt),
      .underflow  (underflow)
   );

   // Clock, 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] v);
      mem[wr_ptr % 16] = v;
      wr_ptr++;
   endtask

   // Four back-to-back beats with out_ready=1; 'now' means beat 0 is already visible.
   task automatic burst(input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3,
                        input int base, input bit now);
      logic [7:0] exp_d [4];
      exp_d = '{b0, b1, b2, b3};
      for (int i = 0; i < 4; i++) begin
         if (!(i == 0 && now)) @(negedge clk);
         #1;
         chk("burst_valid", 32'(out_valid), 32'd1);
         chk("burst_data",  32'(out_data),  32'(exp_d[i]));
         chk("burst_last",  32'(out_last),  32'(i == 3));
         chk("burst_cnt",   32'(xfer_cnt),  32'(base + i));
         chk("burst_pop",   32'(fifo_pop),  32'(i < 3));
      end
      @(negedge clk);
      #1;
      chk("burst_end_valid", 32'(out_valid), 32'd0);
      chk("burst_end_last",  32'(out_last),  32'd0);
      chk("burst_end_cnt",   32'(xfer_cnt),  32'(base + 4));
      chk("burst_end_pop",   32'(fifo_pop),  32'd0);
   endtask

   initial begin
      // Reset with a preloaded FIFO: pop must stay low while in reset.
      reset     = 1'b0;
      enable    = 1'b1;
      out_ready = 1'b1;
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      #1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data",  32'(out_data),  32'd0);
      chk("rst_last",  32'(out_last),  32'd0);
      chk("rst_cnt",   32'(xfer_cnt),  32'd0);
      chk("rst_unf",   32'(underflow), 32'd0);
      chk("rst_pop",   32'(fifo_pop),  32'd0);

      // Full-rate burst.
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rel_pop", 32'(fifo_pop), 32'd1);
      burst(8'h11, 8'h22, 8'h33, 8'h44, 0, 1'b0);

      // Consumer stalls for 5 cycles after the first load.
      out_ready = 1'b0;
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      #1;
      chk("stall_pop0", 32'(fifo_pop), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         chk("stall_valid", 32'(out_valid), 32'd1);
         chk("stall_data",  32'(out_data),  32'h11);
         chk("stall_pop",   32'(fifo_pop),  32'd0);
         chk("stall_last",  32'(out_last),  32'd0);
      end
      out_ready = 1'b1;
      #1;
      burst(8'h11, 8'h22, 8'h33, 8'h44, 4, 1'b1);

      // Empty FIFO, then a single word.
      @(negedge clk);
      #1;
      chk("empty_pop",   32'(fifo_pop),  32'd0);
      chk("empty_valid", 32'(out_valid), 32'd0);
      push(8'hA5);
      #1;
      chk("single_pop", 32'(fifo_pop), 32'd1);
      @(negedge clk);
      #1;
      chk("single_valid", 32'(out_valid), 32'd1);
      chk("single_data",  32'(out_data),  32'hA5);
      chk("single_last",  32'(out_last),  32'd0);
      chk("single_pop2",  32'(fifo_pop),  32'd0);
      @(negedge clk);
      #1;
      chk("single_end_valid", 32'(out_valid), 32'd0);
      chk("single_end_cnt",   32'(xfer_cnt),  32'd9);

      // Underflow: FIFO claims non-empty but returns no data.
      fake_nonempty = 1'b1;
      kill_valid    = 1'b1;
      #1;
      chk("unf_pop",    32'(fifo_pop),  32'd1);
      chk("unf_before", 32'(underflow), 32'd0);
      @(negedge clk);
      #1;
      chk("unf_set",   32'(underflow), 32'd1);
      chk("unf_valid", 32'(out_valid), 32'd0);
      chk("unf_data",  32'(out_data),  32'hA5);
      chk("unf_cnt",   32'(xfer_cnt),  32'd9);
      fake_nonempty = 1'b0;
      kill_valid    = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk("unf_sticky", 32'(underflow), 32'd1);
      end

      // Enable dropped while holding a word: it still drains, no new pops.
      out_ready = 1'b0;
      push(8'h5A);
      #1;
      chk("en_pop", 32'(fifo_pop), 32'd1);
      @(negedge clk);
      enable = 1'b0;
      push(8'h77);
      #1;
      chk("en_hold_valid", 32'(out_valid), 32'd1);
      chk("en_hold_data",  32'(out_data),  32'h5A);
      chk("en_hold_pop",   32'(fifo_pop),  32'd0);
      @(negedge clk);
      #1;
      chk("en_hold_data2", 32'(out_data), 32'h5A);
      out_ready = 1'b1;
      #1;
      chk("en_ready_pop", 32'(fifo_pop), 32'd0);
      @(negedge clk);
      #1;
      chk("en_done_valid", 32'(out_valid), 32'd0);
      chk("en_done_cnt",   32'(xfer_cnt),  32'd10);
      chk("en_done_pop",   32'(fifo_pop),  32'd0);
      chk("en_done_unf",   32'(underflow), 32'd1);

      // Reset mid-burst (beat 2) with a word held.
      enable    = 1'b1;
      out_ready = 1'b0;
      #1;
      chk("mid_pop", 32'(fifo_pop), 32'd1);
      @(negedge clk);
      #1;
      chk("mid_valid", 32'(out_valid), 32'd1);
      chk("mid_data",  32'(out_data),  32'h77);
      chk("mid_last",  32'(out_last),  32'd0);
      push(8'h01); push(8'h02); push(8'h03); push(8'h04);
      #1;
      reset = 1'b0;
      #1;
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_data",  32'(out_data),  32'd0);
      chk("arst_last",  32'(out_last),  32'd0);
      chk("arst_cnt",   32'(xfer_cnt),  32'd0);
      chk("arst_unf",   32'(underflow), 32'd0);
      chk("arst_pop",   32'(fifo_pop),  32'd0);
      @(negedge clk);
      reset     = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("rerel_pop", 32'(fifo_pop), 32'd1);
      burst(8'h01, 8'h02, 8'h03, 8'h04, 0, 1'b0);
      chk("final_unf", 32'(underflow), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
